// File: rtl/uart_score_cmd_parser_pkg.sv
// Shared frame constants, command codes, FSM encodings and score helpers for the
// UART score command parser.
package uart_score_cmd_parser_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  localparam logic [7:0] CMD_SET_HOME  = 8'h01;
  localparam logic [7:0] CMD_SET_GUEST = 8'h02;
  localparam logic [7:0] CMD_INC_HOME  = 8'h03;
  localparam logic [7:0] CMD_INC_GUEST = 8'h04;
  localparam logic [7:0] CMD_CLEAR     = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ARG  = 2'd2,
    ST_CHK  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] home;
    logic [7:0] guest;
  } scores_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max_v);
    return (v >= max_v) ? max_v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_byte_strobe.sv
// RX_DONE rising-edge detect: byte_vld is high only in the first cycle of a DONE
// level, byte_dat passes RX_DATA through that same cycle. Zero latency, no backpressure.
module uart_rx_byte_strobe (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_done,
  input  logic [7:0] i_rx_data,
  output logic       o_byte_vld,
  output logic [7:0] o_byte_dat
);

  logic r_done_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_done_q <= 1'b0;
    else          r_done_q <= i_rx_done;
  end

  assign o_byte_vld = i_rx_done & ~r_done_q;
  assign o_byte_dat = i_rx_data;

endmodule

// File: rtl/uart_score_cmd_parser.sv
// Assembles A5/CMD/ARG/CHK frames, updates home/guest scores and requests ACK/NAK.
// Results appear 1 cycle after the CHK byte; no backpressure from the transmitter.
module uart_score_cmd_parser
  import uart_score_cmd_parser_pkg::*;
#(
  parameter int MAX_SCORE      = 99,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TO_W           = 16
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_DONE,
  output logic [7:0] SCORE_HOME,
  output logic [7:0] SCORE_GUEST,
  output logic       FRAME_OK,
  output logic       FRAME_ERR,
  output logic [7:0] TX_DATA,
  output logic       TX_TRG
);

  localparam logic [7:0]      MAX_B   = 8'(MAX_SCORE);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic       w_byte_vld;
  logic [7:0] w_byte_dat;

  uart_rx_byte_strobe u_strobe (
    .i_clk      (CLK_50MHZ),
    .i_rst_n    (RST),
    .i_rx_done  (RX_DONE),
    .i_rx_data  (RX_DATA),
    .o_byte_vld (w_byte_vld),
    .o_byte_dat (w_byte_dat)
  );

  state_e          r_state, w_state_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic [7:0]      r_cmd, r_arg, w_cmd_nxt, w_arg_nxt;
  scores_t         r_score, w_score_nxt, w_exec_score;
  logic            w_exec_ok;
  logic            r_ok, r_err, r_trg, w_ok_nxt, w_err_nxt, w_trg_nxt;
  logic [7:0]      r_tx, w_tx_nxt;

  // Frame evaluation against the incoming CHK byte; only used in ST_CHK on accept.
  always_comb begin
    w_exec_ok    = 1'b0;
    w_exec_score = r_score;
    if (w_byte_dat == (r_cmd ^ r_arg)) begin
      case (r_cmd)
        CMD_SET_HOME: if (r_arg <= MAX_B) begin
          w_exec_ok          = 1'b1;
          w_exec_score.home  = r_arg;
        end
        CMD_SET_GUEST: if (r_arg <= MAX_B) begin
          w_exec_ok          = 1'b1;
          w_exec_score.guest = r_arg;
        end
        CMD_INC_HOME: begin
          w_exec_ok          = 1'b1;
          w_exec_score.home  = sat_inc(r_score.home, MAX_B);
        end
        CMD_INC_GUEST: begin
          w_exec_ok          = 1'b1;
          w_exec_score.guest = sat_inc(r_score.guest, MAX_B);
        end
        CMD_CLEAR: begin
          w_exec_ok          = 1'b1;
          w_exec_score       = '0;
        end
        default: w_exec_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = '0;
    w_cmd_nxt   = r_cmd;
    w_arg_nxt   = r_arg;
    w_score_nxt = r_score;
    w_ok_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_trg_nxt   = 1'b0;
    w_tx_nxt    = r_tx;

    // Inter-byte gap timer; an accept in the terminal cycle takes priority.
    if (r_state != ST_IDLE && !w_byte_vld) begin
      if (r_to_cnt == TO_LAST) begin
        w_state_nxt = ST_IDLE;
        w_err_nxt   = 1'b1;
        w_trg_nxt   = 1'b1;
        w_tx_nxt    = NAK_BYTE;
      end else begin
        w_to_nxt    = r_to_cnt + 1'b1;
      end
    end

    if (w_byte_vld) begin
      case (r_state)
        ST_IDLE: if (w_byte_dat == SYNC_BYTE) w_state_nxt = ST_CMD;
        ST_CMD: begin
          w_cmd_nxt   = w_byte_dat;
          w_state_nxt = ST_ARG;
        end
        ST_ARG: begin
          w_arg_nxt   = w_byte_dat;
          w_state_nxt = ST_CHK;
        end
        ST_CHK: begin
          w_state_nxt = ST_IDLE;
          w_trg_nxt   = 1'b1;
          if (w_exec_ok) begin
            w_score_nxt = w_exec_score;
            w_ok_nxt    = 1'b1;
            w_tx_nxt    = ACK_BYTE;
          end else begin
            w_err_nxt   = 1'b1;
            w_tx_nxt    = NAK_BYTE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST) begin
      r_state  <= ST_IDLE;
      r_to_cnt <= '0;
      r_cmd    <= '0;
      r_arg    <= '0;
      r_score  <= '0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
      r_trg    <= 1'b0;
      r_tx     <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_nxt;
      r_cmd    <= w_cmd_nxt;
      r_arg    <= w_arg_nxt;
      r_score  <= w_score_nxt;
      r_ok     <= w_ok_nxt;
      r_err    <= w_err_nxt;
      r_trg    <= w_trg_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

  assign SCORE_HOME  = r_score.home;
  assign SCORE_GUEST = r_score.guest;
  assign FRAME_OK    = r_ok;
  assign FRAME_ERR   = r_err;
  assign TX_DATA     = r_tx;
  assign TX_TRG      = r_trg;

endmodule
